// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, transmitter FSM states and the
// baud rate table with its divider helper. Used by the transmitter and receiver.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Indexed by baud_select 3'b000..3'b111.
   localparam int unsigned BAUD_TABLE [0:7] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

   // Clocks per sample tick, truncated.
   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned oversample,
                                            input logic [2:0]  sel);
      return clk_hz / (oversample * BAUD_TABLE[sel]);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample tick generator: divides clk down to OVERSAMPLE ticks per bit period
// for the rate chosen by baud_select.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   baud_select rate index into the baud table
//   tick        one-cycle pulse each time the divider wraps
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] baud_select,
   output logic       tick
);

   // Slowest rate has the largest divider; it sizes the counter.
   localparam int unsigned MAX_DIV = baud_div(CLK_HZ, OVERSAMPLE, 3'd0);
   localparam int unsigned CNT_W   = $clog2(MAX_DIV + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_m1;
   logic [2:0]       sel_q;

   // Constant table lookup so no run-time divider is built.
   always_comb begin
      div_m1 = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (sel_q == 3'(i)) begin
            div_m1 = CNT_W'(baud_div(CLK_HZ, OVERSAMPLE, 3'(i)) - 1);
         end
      end
   end

   // A pending rate change suppresses the tick; the counter restarts next clock.
   assign tick = (cnt == div_m1) && (baud_select == sel_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         sel_q <= '0;
      end else if (baud_select != sel_q) begin
         sel_q <= baud_select;
         cnt   <= '0;
      end else if (cnt == div_m1) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with write FIFO, run-time parity and stop-bit
// selection, and its own oversampling baud tick.
//   Clk, reset     clock and asynchronous active-low reset
//   Tx_WR, Tx_EN   write strobe and transmitter enable (enable also gates writes)
//   Tx_DATA        word to send, LSB first
//   baud_select    rate index; parity_mode 00/11 none, 01 even, 10 odd
//   stop_bits      0 = one stop bit, 1 = two
//   Tx_BUSY        frame in progress or FIFO non-empty
//   Tx_FULL        FIFO full (registered)
//   Tx_OVF         one-cycle pulse when a write is dropped
//   TxD            serial line, idle high
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic                  Tx_WR,
   input  logic                  Tx_EN,
   input  logic [DATA_WIDTH-1:0] Tx_DATA,
   input  logic [2:0]            baud_select,
   input  logic [1:0]            parity_mode,
   input  logic                  stop_bits,
   output logic                  Tx_BUSY,
   output logic                  Tx_FULL,
   output logic                  Tx_OVF,
   output logic                  TxD
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

   logic                  tick;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count, count_n;
   logic                  full_q, ovf_q, fifo_empty;
   logic                  push, pop, drop;

   tx_state_t             state, state_n;
   logic [OS_W-1:0]       os_cnt;
   logic [BIT_W-1:0]      bit_idx;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_en, par_bit, stop_two, stop_idx;
   logic                  bit_end, txd_c;

   uart_baud_tick #(
      .CLK_HZ     (CLK_HZ),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk         (Clk),
      .rst_n       (reset),
      .baud_select (baud_select),
      .tick        (tick)
   );

   // ---------------- write FIFO ----------------
   assign fifo_empty = (count == '0);
   // A pop in the same cycle frees the slot, so a write to a full FIFO succeeds.
   assign push = Tx_WR && Tx_EN && (!full_q || pop);
   assign drop = Tx_WR && Tx_EN && full_q && !pop;

   always_comb begin
      count_n = count;
      if (push && !pop) begin
         count_n = count + 1'b1;
      end else if (pop && !push) begin
         count_n = count - 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= Tx_DATA;
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count  <= count_n;
         full_q <= (count_n == CNT_W'(FIFO_DEPTH));
         ovf_q  <= drop;
      end
   end

   // ---------------- transmit FSM ----------------
   assign bit_end = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      txd_c   = 1'b1;
      case (state)
         ST_IDLE: begin
            if (tick && !fifo_empty && Tx_EN) begin
               pop     = 1'b1;
               state_n = ST_START;
            end
         end
         ST_START: begin
            txd_c = 1'b0;
            if (bit_end) state_n = ST_DATA;
         end
         ST_DATA: begin
            txd_c = shreg[0];
            if (bit_end && bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
               state_n = par_en ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            txd_c = par_bit;
            if (bit_end) state_n = ST_STOP;
         end
         ST_STOP: begin
            if (bit_end && (stop_idx || !stop_two)) begin
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty && Tx_EN) begin
                  pop     = 1'b1;
                  state_n = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Frame configuration and parity are captured with the word at pop time.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         os_cnt   <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         stop_two <= 1'b0;
         stop_idx <= 1'b0;
      end else if (pop) begin
         shreg    <= mem[rd_ptr];
         par_en   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
         par_bit  <= (^mem[rd_ptr]) ^ (parity_mode == PAR_ODD);
         stop_two <= stop_bits;
         stop_idx <= 1'b0;
         os_cnt   <= '0;
         bit_idx  <= '0;
      end else if (tick && state != ST_IDLE) begin
         os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
         if (bit_end && state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
         end
         if (bit_end && state == ST_STOP) begin
            stop_idx <= 1'b1;
         end
      end
   end

   assign TxD     = txd_c;
   assign Tx_BUSY = (state != ST_IDLE) || !fifo_empty;
   assign Tx_FULL = full_q;
   assign Tx_OVF  = ovf_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: expected serial frames are built as
// bit lists from data/parity/stop settings and compared at mid-bit.
module tb_uart_tx_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_wr = 1'b0, tx_en = 1'b0;
   logic [7:0] tx_data = '0;
   logic       wr5 = 1'b0, en5 = 1'b0;
   logic [4:0] data5 = '0;
   logic [2:0] baud_sel = 3'd7;
   logic [1:0] par_mode = 2'd1;
   logic       stop_b = 1'b0;
   logic       busy, full, ovf, txd;
   logic       busy5, full5, ovf5, txd5;
   logic       sel5 = 1'b0;
   logic       txd_m, busy_m;

   int tests = 0;
   int fails = 0;

   int q_data[$];
   int q_mode[$];
   int q_stop[$];

   always #10 clk = ~clk;

   uart_tx_param dut (
      .Clk(clk), .reset(rst_n), .Tx_WR(tx_wr), .Tx_EN(tx_en), .Tx_DATA(tx_data),
      .baud_select(baud_sel), .parity_mode(par_mode), .stop_bits(stop_b),
      .Tx_BUSY(busy), .Tx_FULL(full), .Tx_OVF(ovf), .TxD(txd)
   );

   uart_tx_param #(.DATA_WIDTH(5)) dut5 (
      .Clk(clk), .reset(rst_n), .Tx_WR(wr5), .Tx_EN(en5), .Tx_DATA(data5),
      .baud_select(baud_sel), .parity_mode(par_mode), .stop_bits(stop_b),
      .Tx_BUSY(busy5), .Tx_FULL(full5), .Tx_OVF(ovf5), .TxD(txd5)
   );

   always_comb begin
      txd_m  = sel5 ? txd5 : txd;
      busy_m = sel5 ? busy5 : busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push8(input logic [7:0] d);
      tx_data = d;
      tx_wr   = 1'b1;
      tick_n(1);
      tx_wr   = 1'b0;
   endtask

   function automatic int bit_period(input int sel);
      int rates[8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
      return (50_000_000 / (16 * rates[sel])) * 16;
   endfunction

   // Expects the queued frames back-to-back starting from an idle line.
   task automatic check_stream(input int dw, input int bp, input string tag);
      bit bits[$];
      int n, ones, b;
      foreach (q_data[f]) begin
         bits.push_back(1'b0);
         ones = 0;
         for (int i = 0; i < dw; i++) begin
            b = (q_data[f] >> i) & 1;
            ones += b;
            bits.push_back(b[0]);
         end
         if (q_mode[f] == 1) bits.push_back(ones % 2 == 1);
         if (q_mode[f] == 2) bits.push_back(ones % 2 == 0);
         bits.push_back(1'b1);
         if (q_stop[f] == 1) bits.push_back(1'b1);
      end
      q_data.delete(); q_mode.delete(); q_stop.delete();
      n = 0;
      while (txd_m !== 1'b0 && n < 40000) begin
         tick_n(1);
         n++;
      end
      if (txd_m !== 1'b0) begin
         chk({tag, " start_timeout"}, 32'(txd_m), 32'd0);
         return;
      end
      tick_n(bp / 2);
      foreach (bits[k]) begin
         chk($sformatf("%s bit%0d", tag, k), 32'(txd_m), 32'(bits[k]));
         chk($sformatf("%s busy%0d", tag, k), 32'(busy_m), 32'd1);
         if (k < bits.size() - 1) tick_n(bp);
      end
      tick_n(bp - bp / 2 - 1);
      chk({tag, " busy_last_cycle"}, 32'(busy_m), 32'd1);
      tick_n(1);
      chk({tag, " busy_fall"}, 32'(busy_m), 32'd0);
      chk({tag, " idle_line"}, 32'(txd_m), 32'd1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bp, ovf_cnt, n, bad, mode, stp;
      logic [7:0] w;
      bp = bit_period(7);

      // reset state
      tick_n(3);
      chk("rst txd", 32'(txd), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst full", 32'(full), 32'd0);
      chk("rst ovf", 32'(ovf), 32'd0);
      chk("rst txd5", 32'(txd5), 32'd1);
      rst_n = 1'b1;
      tick_n(2);

      // 8E1 0xA5
      tx_en = 1'b1;
      push8(8'hA5);
      chk("busy_rise", 32'(busy), 32'd1);
      q_data.push_back(8'hA5); q_mode.push_back(1); q_stop.push_back(0);
      check_stream(8, bp, "8E1");

      // odd parity, then no parity
      par_mode = 2'd2;
      push8(8'hA5);
      q_data.push_back(8'hA5); q_mode.push_back(2); q_stop.push_back(0);
      check_stream(8, bp, "8O1");
      par_mode = 2'd0;
      push8(8'hA5);
      q_data.push_back(8'hA5); q_mode.push_back(0); q_stop.push_back(0);
      check_stream(8, bp, "8N1");

      // FIFO fill with ticks held off by a rate change, overflow, then burst
      par_mode = 2'd1;
      tx_en    = 1'b0;
      baud_sel = 3'd6;
      tick_n(2);
      tx_data = 8'h3C; tx_wr = 1'b1;
      tick_n(1);
      tx_wr = 1'b0;
      chk("en0 no_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 4; i++) begin
         w = 8'($urandom);
         tx_en = 1'b1;
         push8(w);
         tx_en = 1'b0;
         q_data.push_back(w); q_mode.push_back(1); q_stop.push_back(0);
         chk($sformatf("push%0d no_ovf", i), 32'(ovf), 32'd0);
         if (i == 2) chk("full after3", 32'(full), 32'd0);
      end
      chk("full after4", 32'(full), 32'd1);
      tx_en = 1'b1;
      push8(8'hFF);
      tx_en = 1'b0;
      ovf_cnt = 0;
      for (int j = 0; j < 5; j++) begin
         if (ovf === 1'b1) ovf_cnt++;
         tick_n(1);
      end
      chk("ovf pulse_cycles", 32'(ovf_cnt), 32'd1);
      chk("full held", 32'(full), 32'd1);
      baud_sel = 3'd7;
      tick_n(1);
      tx_en = 1'b1;
      check_stream(8, bp, "burst");

      // 5-bit payload, two stop bits, no parity
      sel5 = 1'b1; par_mode = 2'd0; stop_b = 1'b1; en5 = 1'b1;
      data5 = 5'h13; wr5 = 1'b1;
      tick_n(1);
      wr5 = 1'b0;
      q_data.push_back(5'h13); q_mode.push_back(0); q_stop.push_back(1);
      check_stream(5, bp, "dw5");
      sel5 = 1'b0; en5 = 1'b0;

      // reset during data bit 3
      par_mode = 2'd1; stop_b = 1'b0;
      push8(8'h52);
      push8(8'h0F);
      n = 0;
      while (txd !== 1'b0 && n < 40000) begin
         tick_n(1);
         n++;
      end
      chk("rstmid start", 32'(txd), 32'd0);
      tick_n(4 * bp + bp / 2);
      chk("rstmid pre_bit3", 32'(txd), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rstmid txd", 32'(txd), 32'd1);
      chk("rstmid busy", 32'(busy), 32'd0);
      chk("rstmid full", 32'(full), 32'd0);
      tick_n(2);
      rst_n = 1'b1;
      bad = 0;
      for (int j = 0; j < 3 * bp; j++) begin
         tick_n(1);
         if (txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("rstmid stays_idle", 32'(bad), 32'd0);

      // parity/stop change mid-frame applies only to the next frame
      w = 8'($urandom);
      push8(w);
      q_data.push_back(w); q_mode.push_back(1); q_stop.push_back(0);
      w = 8'($urandom);
      push8(w);
      q_data.push_back(w); q_mode.push_back(2); q_stop.push_back(1);
      fork
         check_stream(8, bp, "cfgchg");
         begin
            tick_n(1000);
            par_mode = 2'd2;
            stop_b   = 1'b1;
         end
      join

      // randomized single frames
      for (int r = 0; r < 2; r++) begin
         mode = $urandom_range(0, 3);
         stp  = $urandom_range(0, 1);
         w    = 8'($urandom);
         par_mode = 2'(mode);
         stop_b   = stp[0];
         push8(w);
         q_data.push_back(w); q_mode.push_back(mode); q_stop.push_back(stp);
         check_stream(8, bp, $sformatf("rand%0d", r));
      end

      // 57600 baud
      baud_sel = 3'd6; par_mode = 2'd0; stop_b = 1'b0;
      tick_n(2);
      w = 8'($urandom);
      push8(w);
      q_data.push_back(w); q_mode.push_back(0); q_stop.push_back(0);
      check_stream(8, bit_period(6), "b57600");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
